// File: rtl/bitstream_framer.sv
// Serial frame extractor: hunts for a sync word, then a length field, and
// flags the payload and trailer bits that follow so a checksum can run downstream.
module bitstream_framer #(
    parameter logic [15:0] SYNC_WORD = 16'hA5C3,
    parameter int          LEN_W     = 16,
    parameter int          TRAIL_W   = 32,
    parameter int          MAX_LEN   = 16'h4000
) (
    input  logic             tck_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             data_i,
    output logic             data_o,
    output logic             payload_en_o,
    output logic             trailer_en_o,
    output logic [LEN_W-1:0] frame_len_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       dbg_state,
    output logic [15:0]      dbg_sr
);

    // Wide enough for the length value, the length-bit count and the trailer count.
    localparam int TW = $clog2(TRAIL_W + 1);
    localparam int CW = (LEN_W > TW) ? LEN_W : TW;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_TRAILER = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [15:0]      sr, sr_next;
    logic [CW-1:0]    cnt, cnt_next, cnt_dec;
    logic [LEN_W-1:0] len_next, len_shift;
    logic [15:0]      sync_shift;
    logic             cnt_last;

    assign data_o     = data_i;
    assign done_o     = (state == S_DONE);
    assign err_o      = (state == S_ERR);
    assign dbg_state  = state;
    assign dbg_sr     = sr;
    assign sync_shift = {sr[14:0], data_i};
    assign len_shift  = {frame_len_o[LEN_W-2:0], data_i};
    assign cnt_last   = (cnt == CW'(1));
    assign cnt_dec    = (cnt != '0) ? cnt - CW'(1) : cnt;

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            state       <= S_HUNT;
            sr          <= '0;
            cnt         <= '0;
            frame_len_o <= '0;
        end else begin
            state       <= state_next;
            sr          <= sr_next;
            cnt         <= cnt_next;
            frame_len_o <= len_next;
        end
    end

    // Enables are gated by rst_i so a mid-frame reset silences them in the same cycle.
    always_comb begin
        state_next   = state;
        sr_next      = sr;
        cnt_next     = cnt;
        len_next     = frame_len_o;
        payload_en_o = 1'b0;
        trailer_en_o = 1'b0;
        case (state)
            S_HUNT: begin
                if (en_i) begin
                    sr_next = sync_shift;
                    if (sync_shift == SYNC_WORD) begin
                        state_next = S_LEN;
                        cnt_next   = CW'(LEN_W);
                        len_next   = '0;
                    end
                end
            end
            S_LEN: begin
                if (en_i) begin
                    len_next = len_shift;
                    cnt_next = cnt_dec;
                    if (cnt_last) begin
                        if (len_shift == '0 || len_shift > MAX_L) begin
                            state_next = S_ERR;
                        end else begin
                            state_next = S_PAYLOAD;
                            cnt_next   = CW'(len_shift);
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                payload_en_o = en_i && !rst_i;
                if (en_i) begin
                    cnt_next = cnt_dec;
                    if (cnt_last) begin
                        state_next = S_TRAILER;
                        cnt_next   = CW'(TRAIL_W);
                    end
                end
            end
            S_TRAILER: begin
                trailer_en_o = en_i && !rst_i;
                if (en_i) begin
                    cnt_next = cnt_dec;
                    if (cnt_last) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_HUNT;
        endcase
    end

endmodule

// File: tb/tb_bitstream_framer.sv
// Bench for bitstream_framer: frames are built bit by bit, each bit's expected
// enable class is queued as it is driven and compared against the DUT mid-cycle.
module tb_bitstream_framer;

    logic        tck_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        data_i;
    logic        data_o;
    logic        payload_en_o;
    logic        trailer_en_o;
    logic [15:0] frame_len_o;
    logic        done_o;
    logic        err_o;
    logic [2:0]  dbg_state;
    logic [15:0] dbg_sr;

    int checks = 0;
    int errors = 0;
    int pay_seen;
    int trl_seen;
    logic [1:0] exp_q[$];

    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_PAY  = 2'b10;
    localparam logic [1:0] K_TRL  = 2'b01;

    bitstream_framer dut (
        .tck_i        (tck_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .payload_en_o (payload_en_o),
        .trailer_en_o (trailer_en_o),
        .frame_len_o  (frame_len_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .dbg_state    (dbg_state),
        .dbg_sr       (dbg_sr)
    );

    always #5 tck_i = ~tck_i;

    // Called at posedge+1; drives one cycle, checks enables at the negedge.
    task automatic drive(input logic b, input logic en, input logic rst, input logic [1:0] kind);
        logic [1:0] exp;
        logic [1:0] got;
        data_i = b;
        en_i   = en;
        rst_i  = rst;
        exp_q.push_back((en && !rst) ? kind : K_NONE);
        @(negedge tck_i);
        exp = exp_q.pop_front();
        got = {payload_en_o, trailer_en_o};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL enables: got pay/trl=%b required %b at %0t", got, exp, $time);
        end
        checks++;
        if (data_o !== b) begin
            errors++;
            $display("FAIL data_copy: got %b required %b at %0t", data_o, b, $time);
        end
        if (payload_en_o === 1'b1) pay_seen++;
        if (trailer_en_o === 1'b1) trl_seen++;
        @(posedge tck_i);
        #1;
    endtask

    task automatic send_field(input logic [63:0] val, input int n, input logic [1:0] kind, input bit toggle);
        for (int i = n - 1; i >= 0; i--) begin
            drive(val[i], 1'b1, 1'b0, kind);
            if (toggle) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, kind);
        end
    endtask

    task automatic send_frame(input logic [15:0] len, input int npay, input bit toggle,
                              input logic [1:0] pk, input logic [1:0] tk);
        send_field(64'hA5C3, 16, K_NONE, toggle);
        send_field({48'h0, len}, 16, K_NONE, toggle);
        send_field({$urandom(), $urandom()}, npay, pk, toggle);
        send_field({$urandom(), $urandom()}, 32, tk, toggle);
    endtask

    task automatic do_reset();
        drive(1'($urandom_range(0, 1)), 1'b1, 1'b1, K_NONE);
        pay_seen = 0;
        trl_seen = 0;
    endtask

    task automatic test_reset();
        checks++;
        if (done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got done=%b err=%b required 0 0", done_o, err_o);
        end
        checks++;
        if (frame_len_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_len: got %h required 0000", frame_len_o);
        end
        checks++;
        if (dbg_state !== 3'd0 || dbg_sr !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d sr=%h required 0 0000", dbg_state, dbg_sr);
        end
    endtask

    task automatic test_basic_frame();
        do_reset();
        send_frame(16'h0008, 8, 1'b0, K_PAY, K_TRL);
        checks++;
        if (pay_seen != 8 || trl_seen != 32) begin
            errors++;
            $display("FAIL basic_counts: got pay=%0d trl=%0d required 8 32", pay_seen, trl_seen);
        end
        checks++;
        if (done_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b err=%b required 1 0", done_o, err_o);
        end
        checks++;
        if (frame_len_o !== 16'h0008) begin
            errors++;
            $display("FAIL basic_len: got %h required 0008", frame_len_o);
        end
    endtask

    task automatic test_back_to_back();
        // DONE is terminal: a second frame must be ignored entirely.
        pay_seen = 0;
        trl_seen = 0;
        send_frame(16'h0005, 5, 1'b0, K_NONE, K_NONE);
        checks++;
        if (done_o !== 1'b1 || frame_len_o !== 16'h0008 || pay_seen != 0) begin
            errors++;
            $display("FAIL done_sticky: got done=%b len=%h pay=%0d required 1 0008 0",
                     done_o, frame_len_o, pay_seen);
        end
    endtask

    task automatic test_toggle_en();
        do_reset();
        send_frame(16'h0008, 8, 1'b1, K_PAY, K_TRL);
        checks++;
        if (pay_seen != 8 || trl_seen != 32) begin
            errors++;
            $display("FAIL toggle_counts: got pay=%0d trl=%0d required 8 32", pay_seen, trl_seen);
        end
        checks++;
        if (done_o !== 1'b1 || frame_len_o !== 16'h0008) begin
            errors++;
            $display("FAIL toggle_done: got done=%b len=%h required 1 0008", done_o, frame_len_o);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        send_field(64'hA5C3, 16, K_NONE, 1'b0);
        send_field(64'h0000, 16, K_NONE, 1'b0);
        checks++;
        if (err_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_err: got err=%b done=%b required 1 0", err_o, done_o);
        end
        send_field({$urandom(), $urandom()}, 40, K_NONE, 1'b0);
        checks++;
        if (pay_seen != 0 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_quiet: got pay=%0d err=%b required 0 1", pay_seen, err_o);
        end
    endtask

    task automatic test_over_len();
        do_reset();
        send_field(64'hA5C3, 16, K_NONE, 1'b0);
        send_field(64'h4001, 16, K_NONE, 1'b0);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL over_len_err: got err=%b required 1", err_o);
        end
        send_frame(16'h0008, 8, 1'b0, K_NONE, K_NONE);
        checks++;
        if (err_o !== 1'b1 || done_o !== 1'b0 || pay_seen != 0 || trl_seen != 0) begin
            errors++;
            $display("FAIL over_len_ignore: got err=%b done=%b pay=%0d trl=%0d required 1 0 0 0",
                     err_o, done_o, pay_seen, trl_seen);
        end
    endtask

    task automatic test_max_len_ok();
        // Length exactly at the limit is legal; only the length stage is checked.
        do_reset();
        send_field(64'hA5C3, 16, K_NONE, 1'b0);
        send_field(64'h4000, 16, K_NONE, 1'b0);
        drive(1'b1, 1'b1, 1'b0, K_PAY);
        checks++;
        if (err_o !== 1'b0 || frame_len_o !== 16'h4000) begin
            errors++;
            $display("FAIL max_len: got err=%b len=%h required 0 4000", err_o, frame_len_o);
        end
    endtask

    task automatic test_overlap_sync();
        do_reset();
        send_field(64'hA5, 8, K_NONE, 1'b0);
        send_frame(16'h0008, 8, 1'b0, K_PAY, K_TRL);
        checks++;
        if (done_o !== 1'b1 || pay_seen != 8 || trl_seen != 32) begin
            errors++;
            $display("FAIL overlap: got done=%b pay=%0d trl=%0d required 1 8 32", done_o, pay_seen, trl_seen);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_field(64'hA5C3, 16, K_NONE, 1'b0);
        send_field(64'h0008, 16, K_NONE, 1'b0);
        send_field({$urandom(), $urandom()}, 3, K_PAY, 1'b0);
        drive(1'b1, 1'b1, 1'b1, K_PAY);
        checks++;
        if (dbg_state !== 3'd0 || done_o !== 1'b0 || err_o !== 1'b0 || frame_len_o !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: got state=%0d done=%b err=%b len=%h required 0 0 0 0000",
                     dbg_state, done_o, err_o, frame_len_o);
        end
        // Only half a sync word before a reset must not help the next match.
        send_field(64'hA5, 8, K_NONE, 1'b0);
        drive(1'b0, 1'b1, 1'b1, K_NONE);
        send_field(64'hC3, 8, K_NONE, 1'b0);
        checks++;
        if (dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL stale_sync: got state=%0d required 0", dbg_state);
        end
        pay_seen = 0;
        trl_seen = 0;
        send_frame(16'h0008, 8, 1'b0, K_PAY, K_TRL);
        checks++;
        if (done_o !== 1'b1 || pay_seen != 8 || trl_seen != 32) begin
            errors++;
            $display("FAIL after_reset_frame: got done=%b pay=%0d trl=%0d required 1 8 32",
                     done_o, pay_seen, trl_seen);
        end
    endtask

    initial begin
        rst_i    = 1'b1;
        en_i     = 1'b0;
        data_i   = 1'b0;
        pay_seen = 0;
        trl_seen = 0;
        repeat (2) @(posedge tck_i);
        #1;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_toggle_en();
        test_zero_len();
        test_over_len();
        test_max_len_ok();
        test_overlap_sync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
